// File: rtl/gb_bus_unit_if.sv
// Memory-side bus of the SM83 M-cycle sequencer: address, strobes, data, ready.
interface gb_bus_unit_if;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_wr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    modport master (output mem_addr, mem_rd, mem_wr, mem_wdata,
                    input  mem_rdata, mem_ready);
    modport slave  (input  mem_addr, mem_rd, mem_wr, mem_wdata,
                    output mem_rdata, mem_ready);
endinterface

// File: rtl/gb_bus_unit.sv
// SM83 memory-bus M-cycle sequencer (T1..T4 with wait states) and register-file
// write-back driver for load data and the IDU inc/dec result.
package gb_bus_unit_pkg;
    typedef enum logic [3:0] {
        REG_B, REG_C, REG_D, REG_E, REG_H, REG_L, REG_A, REG_F, REG_W, REG_Z
    } register_n_t;
    typedef enum logic [2:0] {
        REG_BC, REG_DE, REG_HL, REG_SP, REG_PC, REG_WZ, REG_AF
    } register_nn_t;
endpackage

module gb_bus_unit
    import gb_bus_unit_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [7:0]  OPEN_BUS = 8'hFF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req,
    input  logic [1:0]    bus_op,
    input  logic [15:0]   addr_in,
    input  logic [7:0]    wdata_in,
    input  logic          dest_en,
    input  register_n_t   dest_reg,
    input  logic [1:0]    idu_op,
    input  register_nn_t  idu_reg,
    gb_bus_unit_if.master bus,
    output logic          write_r,
    output register_n_t   write_reg_r,
    output logic [7:0]    data_in_r,
    output logic          write_rr,
    output register_nn_t  write_reg_rr,
    output logic [15:0]   data_in_rr,
    output logic          busy,
    output logic          done,
    output logic          timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

    state_t       state, state_nx;
    logic [15:0]  a_addr;
    logic [1:0]   a_op;
    logic [7:0]   a_wdata;
    logic         a_dest_en;
    register_n_t  a_dest_reg;
    logic [1:0]   a_idu_op;
    register_nn_t a_idu_reg;
    logic [7:0]   rdata_q;
    logic [CW-1:0] stall_cnt;
    logic         to_flag;

    logic take, stall, cap_rd, cap_to;
    logic is_rd, is_wr, idu_inc, idu_dec;

    assign is_rd   = (a_op == 2'b01);
    assign is_wr   = (a_op == 2'b10);
    assign idu_inc = (a_idu_op == 2'b01);
    assign idu_dec = (a_idu_op == 2'b10);
    assign take    = req && (state == IDLE || state == T4);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_addr     <= '0;
            a_op       <= '0;
            a_wdata    <= '0;
            a_dest_en  <= 1'b0;
            a_dest_reg <= REG_B;
            a_idu_op   <= '0;
            a_idu_reg  <= REG_BC;
            rdata_q    <= '0;
            stall_cnt  <= '0;
            to_flag    <= 1'b0;
        end else begin
            state <= state_nx;
            if (take) begin
                a_addr     <= addr_in;
                a_op       <= bus_op;
                a_wdata    <= wdata_in;
                a_dest_en  <= dest_en;
                a_dest_reg <= dest_reg;
                a_idu_op   <= idu_op;
                a_idu_reg  <= idu_reg;
                rdata_q    <= '0;
                stall_cnt  <= '0;
                to_flag    <= 1'b0;
            end else begin
                if (stall)  stall_cnt <= stall_cnt + 1'b1;
                if (cap_rd) rdata_q   <= bus.mem_rdata;
                if (cap_to) begin
                    rdata_q <= OPEN_BUS;
                    to_flag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nx = state;
        stall    = 1'b0;
        cap_rd   = 1'b0;
        cap_to   = 1'b0;
        case (state)
            IDLE: if (req) state_nx = T1;
            T1:   state_nx = T2;
            T2:   state_nx = T3;
            T3: begin
                if (!(is_rd || is_wr)) begin
                    state_nx = T4;
                end else if (bus.mem_ready) begin
                    cap_rd   = is_rd;
                    state_nx = T4;
                end else if (stall_cnt == CW'(TIMEOUT - 1)) begin
                    // this not-ready cycle is the TIMEOUT-th stall: give up
                    cap_to   = 1'b1;
                    state_nx = T4;
                end else begin
                    stall = 1'b1;
                end
            end
            T4:      state_nx = req ? T1 : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy          = (state != IDLE);
    assign done          = (state == T4);
    assign timeout       = (state == T4) && to_flag;
    assign bus.mem_addr  = busy ? a_addr : 16'h0000;
    assign bus.mem_rd    = is_rd && (state == T1 || state == T2 || state == T3);
    assign bus.mem_wr    = is_wr && (state == T2 || state == T3);
    assign bus.mem_wdata = bus.mem_wr ? a_wdata : 8'h00;

    assign write_r      = done && is_rd && a_dest_en;
    assign write_reg_r  = write_r ? a_dest_reg : REG_B;
    assign data_in_r    = write_r ? rdata_q : 8'h00;
    assign write_rr     = done && (idu_inc || idu_dec);
    assign write_reg_rr = write_rr ? a_idu_reg : REG_BC;
    assign data_in_rr   = !done  ? 16'h0000 :
                          idu_inc ? a_addr + 16'h0001 :
                          idu_dec ? a_addr - 16'h0001 : 16'h0000;
endmodule

// File: tb/tb_gb_bus_unit.sv
// Directed self-checking bench for gb_bus_unit: reads, writes, IDU wrap,
// wait states, timeout, back-to-back, ignored req and mid-access reset.
module tb_gb_bus_unit;
    import gb_bus_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic req;
    logic [1:0] bus_op;
    logic [15:0] addr_in;
    logic [7:0] wdata_in;
    logic dest_en;
    register_n_t dest_reg;
    logic [1:0] idu_op;
    register_nn_t idu_reg;
    logic write_r, write_rr, busy, done, timeout;
    register_n_t write_reg_r;
    register_nn_t write_reg_rr;
    logic [7:0] data_in_r;
    logic [15:0] data_in_rr;
    int errors = 0;
    int checks = 0;

    gb_bus_unit_if bus();

    gb_bus_unit #(.TIMEOUT(16), .OPEN_BUS(8'hFF)) dut (
        .clk(clk), .rst(rst), .req(req), .bus_op(bus_op), .addr_in(addr_in),
        .wdata_in(wdata_in), .dest_en(dest_en), .dest_reg(dest_reg),
        .idu_op(idu_op), .idu_reg(idu_reg), .bus(bus),
        .write_r(write_r), .write_reg_r(write_reg_r), .data_in_r(data_in_r),
        .write_rr(write_rr), .write_reg_rr(write_reg_rr), .data_in_rr(data_in_rr),
        .busy(busy), .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Drives one request at the current negedge; it is sampled at the next posedge.
    task automatic start(input logic [15:0] a, input logic [1:0] op, input logic [7:0] wd,
                         input logic de, input register_n_t dr,
                         input logic [1:0] io, input register_nn_t ir);
        req = 1'b1; addr_in = a; bus_op = op; wdata_in = wd;
        dest_en = de; dest_reg = dr; idu_op = io; idu_reg = ir;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; req = 1'b0; bus_op = 2'b00; addr_in = '0; wdata_in = '0;
        dest_en = 1'b0; dest_reg = REG_B; idu_op = 2'b00; idu_reg = REG_BC;
        bus.mem_rdata = 8'h00; bus.mem_ready = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++;
        if ({busy, done, timeout, write_r, write_rr, bus.mem_rd, bus.mem_wr} !== 7'b0) begin
            errors++; $display("FAIL reset_ctl got %b exp 0",
                {busy, done, timeout, write_r, write_rr, bus.mem_rd, bus.mem_wr});
        end
        checks++;
        if (bus.mem_addr !== 16'h0000 || data_in_rr !== 16'h0000) begin
            errors++; $display("FAIL reset_data got addr=%h rr=%h exp 0", bus.mem_addr, data_in_rr);
        end
    endtask

    task automatic test_read_inc;
        bus.mem_ready = 1'b1; bus.mem_rdata = 8'h3E;
        start(16'h0150, 2'b01, 8'h00, 1'b1, REG_Z, 2'b01, REG_PC);
        tick(1); req = 1'b0;
        checks++;
        if (bus.mem_addr !== 16'h0150 || bus.mem_rd !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rd_t1 got addr=%h rd=%b busy=%b exp 0150 1 1",
                bus.mem_addr, bus.mem_rd, busy);
        end
        tick(2);
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL rd_early_done got %b exp 0", done); end
        tick(1);
        checks++;
        if (done !== 1'b1 || write_r !== 1'b1 || write_reg_r !== REG_Z || data_in_r !== 8'h3E) begin
            errors++; $display("FAIL rd_wb_r got done=%b w=%b reg=%0d d=%h exp 1 1 %0d 3e",
                done, write_r, write_reg_r, data_in_r, REG_Z);
        end
        checks++;
        if (write_rr !== 1'b1 || write_reg_rr !== REG_PC || data_in_rr !== 16'h0151 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL rd_wb_rr got w=%b reg=%0d d=%h rd=%b exp 1 %0d 0151 0",
                write_rr, write_reg_rr, data_in_rr, bus.mem_rd, REG_PC);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rd_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_write_dec;
        start(16'hFFFE, 2'b10, 8'hA5, 1'b1, REG_A, 2'b10, REG_SP);
        tick(1); req = 1'b0;
        checks++;
        if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL wr_t1 got wr=%b exp 0", bus.mem_wr); end
        tick(1);
        checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 8'hA5 || bus.mem_rd !== 1'b0) begin
            errors++; $display("FAIL wr_t2 got wr=%b wd=%h rd=%b exp 1 a5 0",
                bus.mem_wr, bus.mem_wdata, bus.mem_rd);
        end
        tick(1);
        checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_wdata !== 8'hA5 || bus.mem_addr !== 16'hFFFE) begin
            errors++; $display("FAIL wr_t3 got wr=%b wd=%h a=%h exp 1 a5 fffe",
                bus.mem_wr, bus.mem_wdata, bus.mem_addr);
        end
        tick(1);
        checks++;
        if (done !== 1'b1 || write_r !== 1'b0 || bus.mem_wr !== 1'b0) begin
            errors++; $display("FAIL wr_t4 got done=%b write_r=%b wr=%b exp 1 0 0",
                done, write_r, bus.mem_wr);
        end
        checks++;
        if (write_rr !== 1'b1 || write_reg_rr !== REG_SP || data_in_rr !== 16'hFFFD) begin
            errors++; $display("FAIL wr_wb_rr got w=%b reg=%0d d=%h exp 1 %0d fffd",
                write_rr, write_reg_rr, data_in_rr, REG_SP);
        end
        tick(1);
    endtask

    task automatic test_idu_wrap;
        start(16'hFFFF, 2'b00, 8'h00, 1'b0, REG_B, 2'b01, REG_HL);
        tick(1); req = 1'b0;
        tick(3);
        checks++;
        if (done !== 1'b1 || write_rr !== 1'b1 || data_in_rr !== 16'h0000 || write_r !== 1'b0) begin
            errors++; $display("FAIL idu_inc_wrap got done=%b w=%b d=%h wr=%b exp 1 1 0000 0",
                done, write_rr, data_in_rr, write_r);
        end
        tick(1);
        start(16'h0000, 2'b00, 8'h00, 1'b0, REG_B, 2'b10, REG_BC);
        tick(1); req = 1'b0;
        tick(3);
        checks++;
        if (done !== 1'b1 || write_reg_rr !== REG_BC || data_in_rr !== 16'hFFFF) begin
            errors++; $display("FAIL idu_dec_wrap got done=%b reg=%0d d=%h exp 1 %0d ffff",
                done, write_reg_rr, data_in_rr, REG_BC);
        end
        tick(1);
    endtask

    task automatic test_wait_states;
        bus.mem_ready = 1'b0; bus.mem_rdata = 8'h11;
        start(16'h8000, 2'b01, 8'h00, 1'b1, REG_B, 2'b00, REG_BC);
        tick(1); req = 1'b0;
        tick(3);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || bus.mem_rd !== 1'b1) begin
            errors++; $display("FAIL ws_stall got done=%b busy=%b rd=%b exp 0 1 1", done, busy, bus.mem_rd);
        end
        tick(2);
        bus.mem_ready = 1'b1; bus.mem_rdata = 8'hC3;
        tick(1);
        bus.mem_rdata = 8'h00;
        checks++;
        if (done !== 1'b1 || write_r !== 1'b1 || data_in_r !== 8'hC3 || write_rr !== 1'b0) begin
            errors++; $display("FAIL ws_done got done=%b w=%b d=%h rr=%b exp 1 1 c3 0",
                done, write_r, data_in_r, write_rr);
        end
        tick(1);
    endtask

    task automatic test_timeout;
        bus.mem_ready = 1'b0; bus.mem_rdata = 8'h55;
        start(16'h9000, 2'b01, 8'h00, 1'b1, REG_A, 2'b00, REG_BC);
        tick(1); req = 1'b0;
        tick(17);
        checks++;
        if (done !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL to_early got done=%b to=%b exp 0 0", done, timeout);
        end
        tick(1);
        checks++;
        if (done !== 1'b1 || timeout !== 1'b1 || write_r !== 1'b1 || data_in_r !== 8'hFF) begin
            errors++; $display("FAIL to_done got done=%b to=%b w=%b d=%h exp 1 1 1 ff",
                done, timeout, write_r, data_in_r);
        end
        tick(1);
        checks++;
        if (timeout !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL to_after got to=%b busy=%b exp 0 0", timeout, busy);
        end
        bus.mem_ready = 1'b1;
    endtask

    task automatic test_back_to_back;
        bus.mem_ready = 1'b1; bus.mem_rdata = 8'h77;
        start(16'h1000, 2'b01, 8'h00, 1'b1, REG_C, 2'b01, REG_PC);
        tick(1); addr_in = 16'h2000;
        tick(3);
        checks++;
        if (done !== 1'b1 || data_in_rr !== 16'h1001) begin
            errors++; $display("FAIL b2b_1 got done=%b d=%h exp 1 1001", done, data_in_rr);
        end
        tick(1); addr_in = 16'h3000;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || bus.mem_addr !== 16'h2000) begin
            errors++; $display("FAIL b2b_t1 got busy=%b done=%b a=%h exp 1 0 2000", busy, done, bus.mem_addr);
        end
        tick(3);
        checks++;
        if (done !== 1'b1 || data_in_rr !== 16'h2001 || data_in_r !== 8'h77) begin
            errors++; $display("FAIL b2b_2 got done=%b d=%h r=%h exp 1 2001 77", done, data_in_rr, data_in_r);
        end
        tick(1); req = 1'b0;
        checks++;
        if (bus.mem_addr !== 16'h3000 || busy !== 1'b1) begin
            errors++; $display("FAIL b2b_t1b got a=%h busy=%b exp 3000 1", bus.mem_addr, busy);
        end
        tick(3);
        checks++;
        if (done !== 1'b1 || data_in_rr !== 16'h3001) begin
            errors++; $display("FAIL b2b_3 got done=%b d=%h exp 1 3001", done, data_in_rr);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b exp 0", busy); end
    endtask

    task automatic test_req_ignored;
        start(16'h4000, 2'b00, 8'h00, 1'b0, REG_B, 2'b01, REG_DE);
        tick(1); req = 1'b0;
        tick(1); start(16'h5000, 2'b01, 8'h00, 1'b1, REG_D, 2'b10, REG_HL);
        tick(1); req = 1'b0;
        tick(1);
        checks++;
        if (done !== 1'b1 || write_reg_rr !== REG_DE || data_in_rr !== 16'h4001) begin
            errors++; $display("FAIL ign_done got done=%b reg=%0d d=%h exp 1 %0d 4001",
                done, write_reg_rr, data_in_rr, REG_DE);
        end
        tick(1);
        checks++;
        if (busy !== 1'b0 || bus.mem_addr !== 16'h0000) begin
            errors++; $display("FAIL ign_idle got busy=%b a=%h exp 0 0000", busy, bus.mem_addr);
        end
    endtask

    task automatic test_reset_mid;
        bus.mem_ready = 1'b0;
        start(16'hC000, 2'b01, 8'h00, 1'b1, REG_E, 2'b01, REG_HL);
        tick(1); req = 1'b0;
        tick(2);
        checks++;
        if (bus.mem_rd !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rm_t3 got rd=%b busy=%b exp 1 1", bus.mem_rd, busy);
        end
        rst = 1'b1;
        tick(1);
        rst = 1'b0; bus.mem_ready = 1'b1;
        checks++;
        if ({busy, done, write_r, write_rr, bus.mem_rd, bus.mem_wr} !== 6'b0) begin
            errors++; $display("FAIL rm_ctl got %b exp 0", {busy, done, write_r, write_rr, bus.mem_rd, bus.mem_wr});
        end
        checks++;
        if (bus.mem_addr !== 16'h0000 || data_in_rr !== 16'h0000 || data_in_r !== 8'h00) begin
            errors++; $display("FAIL rm_data got a=%h rr=%h r=%h exp 0", bus.mem_addr, data_in_rr, data_in_r);
        end
        tick(2);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rm_after got done=%b busy=%b exp 0 0", done, busy);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_read_inc();
        test_write_dec();
        test_idu_wrap();
        test_wait_states();
        test_timeout();
        test_back_to_back();
        test_req_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gb_bus_unit.md
Name: gb_bus_unit

Overview:
Memory-bus M-cycle sequencer and register-file write-back driver for the SM83 core. It takes an address (from the register-file 16-bit read port), an op, a destination register and an IDU op from the control unit. It runs one 4-T-cycle bus access with wait-state support and, in T4, drives the register file's 8-bit and 16-bit write ports: load data into the destination register, and the inc/dec address back into the source pair.

Parameters:
TIMEOUT, 16, max T3 stall cycles before an open-bus read (0xFF) is forced
OPEN_BUS, 8'hFF, value captured on a read timeout

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
req  in  1  start M-cycle; sampled in IDLE and T4 only
bus_op  in  2  00 none, 01 read, 10 write, 11 = none
addr_in  in  16  access address; also the IDU source value
wdata_in  in  8  store data
dest_en  in  1  read data is written to dest_reg
dest_reg  in  register_n_t  8-bit write-back target
idu_op  in  2  00 none, 01 inc, 10 dec, 11 = none
idu_reg  in  register_nn_t  16-bit write-back target for the IDU result
mem_addr  out  16  bus address
mem_rd  out  1  read strobe
mem_wr  out  1  write strobe
mem_wdata  out  8  bus write data
mem_rdata  in  8  bus read data
mem_ready  in  1  slave ready; sampled in T3
write_r  out  1  to register file write_r
write_reg_r  out  register_n_t  to register file write_reg_r
data_in_r  out  8  to register file data_in_r
write_rr  out  1  to register file write_rr
write_reg_rr  out  register_nn_t  to register file write_reg_rr
data_in_rr  out  16  to register file data_in_rr
busy  out  1  high in T1..T4
done  out  1  one-cycle pulse in T4
timeout  out  1  one-cycle pulse in T4 of a timed-out read

Behaviour:
- States: IDLE, T1, T2, T3, T4. All outputs are registered or decoded from state plus latched fields.
- Reset: state=IDLE, all latches cleared, every output 0 (mem_addr=0, data_in_rr=0, strobes low). Reset mid-cycle aborts the access immediately, with no write-back and no done.
- IDLE: busy=0. On req=1, latch addr_in, bus_op, wdata_in, dest_en, dest_reg, idu_op, idu_reg. Next state is T1.
- T1: mem_addr=latched addr, held through T4. mem_rd=1 if read.
- T2: mem_rd held for a read. mem_wr=1 and mem_wdata=latched wdata for a write.
- T3: strobes held as in T2.
  - Read or write with mem_ready=1: capture mem_rdata (read), go to T4.
  - mem_ready=0: stay in T3 and increment the stall counter.
  - Counter reaches TIMEOUT: capture OPEN_BUS (read), set the timeout flag, go to T4.
  - bus_op none: skip the ready check and go straight to T4.
- T4: mem_rd=mem_wr=0 and done=1.
  - Read with dest_en=1: write_r=1, write_reg_r=dest_reg, data_in_r=captured data.
  - idu_op inc or dec: write_rr=1, write_reg_rr=idu_reg, data_in_rr=addr±1 modulo 2^16 (FFFF+1=0000, 0000-1=FFFF).
  - Next state: T1 if req=1 (new fields latched, back-to-back), else IDLE.
- Latency: req seen in cycle n leads to done in cycle n+4 with no wait states, plus one cycle per T3 stall. Back-to-back throughput is one M-cycle per 4 clocks.
- req in T1..T3 is ignored (not queued).
- write_r and write_rr may pulse in the same cycle. If both target the same pair, the register file's priority applies (the rr write wins).
- A write access never asserts write_r. The stall counter clears on entry to T1.

Test Plan:
- Read with PC increment: addr=0x0150, op=read, dest=Z, idu=inc PC, mem_rdata=0x3E with ready tied high -> done 4 cycles after req; write_r to Z with 0x3E and write_rr to PC with 0x0151 in the same cycle.
- Write with SP decrement: addr=0xFFFE, op=write, wdata=0xA5, idu=dec SP -> mem_wr high in T2–T3 with mem_wdata=0xA5; write_r=0; write_rr to SP with 0xFFFD.
- IDU wrap: addr=0xFFFF with idu=inc -> data_in_rr=0x0000. addr=0x0000 with idu=dec -> data_in_rr=0xFFFF.
- Wait states: mem_ready low for 3 cycles in T3 -> done at req+7; data captured on the ready cycle. Ready never asserted with TIMEOUT=16 -> data_in_r=0xFF, timeout pulse in T4.
- Back-to-back: req held high for 3 accesses -> T4→T1 with no IDLE gap and done every 4 cycles. A second req pulse issued in T2 is ignored.
- Reset in T3 of a read -> next cycle is IDLE, all outputs 0, no write_r, write_rr or done.
